// File: rtl/sr_drv_pkg.sv
// Shared encodings for the SR pulse driver: command opcodes and FSM states.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_TOG = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GUARD = 2'b10
  } state_e;

  // Resolve a command to "drive s" (1) or "drive r" (0); TOGGLE inverts q.
  function automatic logic op_is_set(input op_e op, input logic q);
    return (op == OP_SET) || ((op == OP_TOG) && !q);
  endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Command handshake between a requester and the SR pulse driver.
interface sr_pulse_driver_if;
  import sr_drv_pkg::*;

  logic req_valid;
  op_e  req_op;
  logic req_ready;

  modport master (output req_valid, output req_op, input  req_ready);
  modport slave  (input  req_valid, input  req_op, output req_ready);
endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable phase down-counter; holds at zero instead of wrapping.
module sr_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives set/reset pulses of fixed width plus a guard gap into a downstream
// SR master-slave flop. s and r come from one FSM register and are only ever
// loaded as complements or both zero, so they can never overlap.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GUARD_CYC = 1,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_pulse_driver_if.slave      bus,
  input  logic                  q_fb,
  output logic                  s,
  output logic                  r,
  output logic                  busy,
  output logic                  done
);

  // Counter reload values: the phase ends on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = (GUARD_CYC == 0) ? '0 : CNT_W'(GUARD_CYC - 1);

  state_e           state;
  logic             accept;
  logic             start;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  assign bus.req_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign start         = accept && (bus.req_op != OP_NOP);

  // Reload the shared counter on entry to DRIVE or GUARD.
  always_comb begin
    load     = 1'b0;
    load_val = PULSE_LD;
    if (start) begin
      load     = 1'b1;
      load_val = PULSE_LD;
    end else if ((state == ST_DRIVE) && zero && (GUARD_CYC != 0)) begin
      load     = 1'b1;
      load_val = GUARD_LD;
    end
  end

  sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // Phase FSM with registered s/r/done; TOGGLE is resolved only at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      s     <= 1'b0;
      r     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRIVE;
            s     <= op_is_set(bus.req_op, q_fb);
            r     <= !op_is_set(bus.req_op, q_fb);
          end
        end
        ST_DRIVE: begin
          if (zero) begin
            s <= 1'b0;
            r <= 1'b0;
            if (GUARD_CYC == 0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_GUARD;
            end
          end
        end
        ST_GUARD: begin
          if (zero) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 2: cycles s or r is held high per command; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter GUARD_CYC, default 1: cycles s=r=0 after each pulse; legal range 0..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 4: width of the shared phase counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: command present.
REQ-007 SHALL have port req_op, input, 2: command code; 00 NOP, 01 CLR, 10 SET, 11 TOGGLE.
REQ-008 SHALL have port req_ready, output, 1: driver can accept a command.
REQ-009 SHALL have port q_fb, input, 1: q fed back from the downstream SR master-slave flop.
REQ-010 SHALL have port s, output, 1: registered set drive to the downstream flop.
REQ-011 SHALL have port r, output, 1: registered reset drive to the downstream flop.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, DRIVE, GUARD.
REQ-015 SHALL drive req_ready=1 exactly when state is IDLE; a command is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-016 SHALL, on accepting NOP, remain in IDLE with s=r=0 and done=0.
REQ-017 SHALL, on accepting SET/CLR, enter DRIVE and assert s (SET) or r (CLR) from the next cycle for exactly PULSE_CYC cycles.
REQ-018 SHALL resolve TOGGLE at the accepting edge only: q_fb=1 resolves to CLR, q_fb=0 to SET; later q_fb changes are ignored.
REQ-019 SHALL, after the last DRIVE cycle, enter GUARD with s=r=0 for GUARD_CYC cycles, or enter IDLE directly when GUARD_CYC=0.
REQ-020 SHALL assert done for exactly one cycle, in the first IDLE cycle following a DRIVE/GUARD sequence.
REQ-021 SHALL never assert s and r in the same cycle, under any input, parameter value or reset sequence.
REQ-022 SHALL ignore req_valid and req_op while busy; commands are not queued, and the requester holds req_valid until accepted.
REQ-023 SHALL give a total command latency of acceptance + PULSE_CYC + GUARD_CYC + 1 cycles until req_ready and done rise.
REQ-024 SHALL count phases with one CNT_W-bit down-counter, loaded on each phase entry and free of wrap-around.

Reset
REQ-025 SHALL, while rst_n=0, force s=0, r=0, busy=0, done=0, state=IDLE and counter=0 asynchronously, including mid-DRIVE or mid-GUARD.
REQ-026 SHALL drive req_ready=1 during and after reset; no command is accepted while rst_n=0.
REQ-027 SHALL emit no done pulse for a sequence aborted by reset.

Structure
REQ-028 SHALL place the req_op encoding and the FSM state encoding in shared package sr_drv_pkg.
REQ-029 SHALL implement the loadable phase down-counter as sub-module sr_pulse_timer (ports: clk, rst_n, load, load_val, zero).

Verification (PULSE_CYC=2, GUARD_CYC=1; edge 0 = accepting edge)
REQ-030 SHALL verify reset: rst_n=0 mid-stream -> s=r=0, busy=0, done=0 and req_ready=1 immediately, without waiting for a clock edge.
REQ-031 SHALL verify SET: SET accepted at edge 0 -> s=1 in cycles 1-2, s=r=0 in cycle 3, req_ready=1 and done=1 in cycle 4, done=0 in cycle 5.
REQ-032 SHALL verify TOGGLE: with q_fb=1 -> r pulse only; with q_fb=0 -> s pulse only; a q_fb toggle during DRIVE does not change the pulse.
REQ-033 SHALL verify back-to-back: req_valid held high with SET then CLR -> CLR accepted at edge 4, r=1 in cycles 5-6, and s&r never both 1.
REQ-034 SHALL verify abort: rst_n=0 in cycle 1 of a SET -> s=0 immediately; after release, IDLE and no done pulse.
REQ-035 SHALL verify NOP: NOP accepted -> s=r=0, busy=0, done=0, req_ready stays 1.
